// File: rtl/aes_host_sequencer.sv
// Host-side sequencer for the AES I/O block's byte-wide register port (DIN/ADDR/WR/START/OK/DOUT).
// Optional WAIT_OK / CHK_FULL watchdog is compiled in when AES_HOST_TIMEOUT_EN is defined.
module aes_host_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TO_W           = 13
) (
  input  logic         CLK,
  input  logic         RSTB,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_op,
  input  logic [2:0]   req_nk,
  input  logic [127:0] req_text,
  input  logic [255:0] req_key,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic [7:0]   DIN,
  output logic [6:0]   ADDR,
  output logic         WR,
  output logic         START,
  input  logic         OK,
  input  logic [7:0]   DOUT
);

  localparam int unsigned AW    = 7;
  localparam int unsigned DW    = 8;
  localparam int unsigned IDX_W = 5;

  localparam logic [AW-1:0] ADDR_TEXT = 7'h00;
  localparam logic [AW-1:0] ADDR_RES  = 7'h10;
  localparam logic [AW-1:0] ADDR_KEY  = 7'h20;
  localparam logic [AW-1:0] ADDR_OP   = 7'h40;
  localparam logic [AW-1:0] ADDR_NK   = 7'h41;
  localparam logic [AW-1:0] ADDR_FULL = 7'h42;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_CFG, S_WR_TEXT, S_WR_KEY, S_CHK_FULL, S_START, S_WAIT_OK, S_RD, S_RESP
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_phase;
  logic                  r_op;
  logic [2:0]            r_nk;
  logic [15:0][DW-1:0]   r_text;
  logic [31:0][DW-1:0]   r_key;
  logic [15:0][DW-1:0]   r_rsp_data;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DW-1:0]         r_din;
  logic [AW-1:0]         r_addr;
  logic                  r_wr;
  logic                  r_start;

  logic [IDX_W-1:0]      w_idx_nxt;
  logic [IDX_W-1:0]      w_key_last;
  logic                  w_nk_ok;
  logic                  w_to_hit;

  assign w_idx_nxt = r_idx + 5'd1;
  assign w_nk_ok   = (req_nk == 3'd3) || (req_nk == 3'd5) || (req_nk == 3'd7);

  // Index of the last key byte written for the registered key size.
  always_comb begin
    w_key_last = 5'd15;
    case (r_nk)
      3'd5:    w_key_last = 5'd23;
      3'd7:    w_key_last = 5'd31;
      default: ;
    endcase
  end

`ifdef AES_HOST_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] r_to;

  // One counter serves both waits: cleared before each phase, counts busy polls or WAIT_OK cycles.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_to <= '0;
    end else if (r_state == S_WR_KEY || r_state == S_START) begin
      r_to <= '0;
    end else if (r_state == S_WAIT_OK && !OK) begin
      r_to <= r_to + 1'b1;
    end else if (r_state == S_CHK_FULL && r_phase && DOUT[0]) begin
      r_to <= r_to + 1'b1;
    end
  end

  assign w_to_hit = (r_to == TO_LAST);
`else
  logic [TO_W-1:0] w_unused_to;
  assign w_unused_to = TO_W'(TIMEOUT_CYCLES);
  assign w_to_hit    = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_phase     <= 1'b0;
      r_op        <= 1'b0;
      r_nk        <= '0;
      r_text      <= '0;
      r_key       <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_din       <= '0;
      r_addr      <= '0;
      r_wr        <= 1'b0;
      r_start     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op       <= req_op;
            r_nk       <= req_nk;
            r_text     <= req_text;
            r_key      <= req_key;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            if (w_nk_ok) begin
              r_state <= S_WR_CFG;
              r_idx   <= '0;
              r_wr    <= 1'b1;
              r_addr  <= ADDR_OP;
              r_din   <= {7'b0, req_op};
            end else begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end
          end
        end
        S_WR_CFG: begin
          if (r_idx == 5'd0) begin
            r_idx  <= 5'd1;
            r_addr <= ADDR_NK;
            r_din  <= {5'b0, r_nk};
          end else begin
            r_state <= S_WR_TEXT;
            r_idx   <= '0;
            r_addr  <= ADDR_TEXT;
            r_din   <= r_text[0];
          end
        end
        S_WR_TEXT: begin
          if (r_idx == 5'd15) begin
            r_state <= S_WR_KEY;
            r_idx   <= '0;
            r_addr  <= ADDR_KEY;
            r_din   <= r_key[0];
          end else begin
            r_idx  <= w_idx_nxt;
            r_addr <= ADDR_TEXT + 7'(w_idx_nxt);
            r_din  <= r_text[w_idx_nxt[3:0]];
          end
        end
        S_WR_KEY: begin
          if (r_idx == w_key_last) begin
            r_state <= S_CHK_FULL;
            r_phase <= 1'b0;
            r_wr    <= 1'b0;
            r_din   <= '0;
            r_addr  <= ADDR_FULL;
          end else begin
            r_idx  <= w_idx_nxt;
            r_addr <= ADDR_KEY + 7'(w_idx_nxt);
            r_din  <= r_key[w_idx_nxt];
          end
        end
        // Phase 0 presents the status address, phase 1 sees its registered read data.
        S_CHK_FULL: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            if (!DOUT[0]) begin
              r_state <= S_START;
              r_start <= 1'b1;
            end else if (w_to_hit) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end
          end
        end
        S_START: begin
          r_start <= 1'b0;
          r_state <= S_WAIT_OK;
        end
        S_WAIT_OK: begin
          if (OK) begin
            r_state <= S_RD;
            r_idx   <= '0;
            r_addr  <= ADDR_RES;
          end else if (w_to_hit) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_data  <= '0;
          end
        end
        // Read pipeline: address i goes out in cycle i, its byte lands one cycle later.
        S_RD: begin
          if (r_idx != 5'd0) begin
            r_rsp_data[4'(r_idx - 5'd1)] <= DOUT;
          end
          if (r_idx == 5'd16) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
          end else begin
            r_idx <= w_idx_nxt;
            if (r_idx < 5'd15) begin
              r_addr <= ADDR_RES + 7'(w_idx_nxt);
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign DIN       = r_din;
  assign ADDR      = r_addr;
  assign WR        = r_wr;
  assign START     = r_start;

endmodule

// File: tb/tb_aes_host_sequencer.sv
// Bench for aes_host_sequencer: register-port responder plus a transaction-level model
// predicting write order, status polls, START, response latency and response payload.
module tb_aes_host_sequencer;

  localparam int unsigned TO_CYC = 16;

  logic         CLK = 1'b0;
  logic         RSTB = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_op = 1'b0;
  logic [2:0]   req_nk = 3'd0;
  logic [127:0] req_text = '0;
  logic [255:0] req_key = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_data;
  logic         rsp_err;
  logic [7:0]   DIN;
  logic [6:0]   ADDR;
  logic         WR;
  logic         START;
  logic         OK = 1'b0;
  logic [7:0]   DOUT = 8'h00;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  aes_host_sequencer #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(5)) dut (
    .CLK(CLK), .RSTB(RSTB),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_nk(req_nk),
    .req_text(req_text), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .DIN(DIN), .ADDR(ADDR), .WR(WR), .START(START), .OK(OK), .DOUT(DOUT)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // ---------------- reference model helpers ----------------
  function automatic bit nk_ok(input logic [2:0] nk);
    return (nk == 3'd3) || (nk == 3'd5) || (nk == 3'd7);
  endfunction

  function automatic int nb_of(input logic [2:0] nk);
    return (nk == 3'd7) ? 32 : (nk == 3'd5) ? 24 : 16;
  endfunction

  // i-th expected register write as {addr, data}
  function automatic logic [14:0] write_at(input logic op, input logic [2:0] nk,
                                           input logic [127:0] text, input logic [255:0] key,
                                           input int i);
    if (i == 0) return {7'h40, 7'b0, op};
    if (i == 1) return {7'h41, 5'b0, nk};
    if (i < 18) return {7'(i - 2), text[8*(i-2) +: 8]};
    return {7'(32 + i - 18), key[8*(i-18) +: 8]};
  endfunction

  // ---------------- I/O block responder ----------------
  int           cfg_full_polls = 0;
  int           cfg_ok_delay   = 1;   // 0 = OK never rises
  logic [127:0] cfg_result     = '0;
  logic [7:0]   mem [0:127];
  int           rd42  = 0;
  int           okcnt = 0;

  always @(posedge CLK) begin
    if (WR) begin
      mem[ADDR] <= DIN;
      rd42      <= 0;
      DOUT      <= 8'h00;
    end else if (ADDR == 7'h42) begin
      DOUT <= (rd42 < 2 * cfg_full_polls) ? 8'h01 : 8'h00;
      rd42 <= rd42 + 1;
    end else begin
      DOUT <= mem[ADDR];
    end
    if (START) begin
      OK    <= 1'b0;
      okcnt <= cfg_ok_delay;
    end else if (okcnt != 0) begin
      okcnt <= okcnt - 1;
      if (okcnt == 1) begin
        OK <= 1'b1;
        for (int k = 0; k < 16; k++) mem[7'(16 + k)] <= cfg_result[8*k +: 8];
      end
    end
  end

  // ---------------- compare process ----------------
  bit           busy = 1'b0;
  int           c, wr_seen, w_total, exp_lat, exp_n42, n42, starts, exp_starts;
  logic         m_op, exp_err;
  logic [2:0]   m_nk;
  logic [127:0] m_text, exp_data;
  logic [255:0] m_key;

  always @(negedge CLK) begin
    if (!RSTB) begin
      chk("reset_outputs", {WR, START, rsp_valid, rsp_err, req_ready, DIN, ADDR, rsp_data},
          {4'b0000, 1'b1, 8'h00, 7'h00, 128'h0});
      busy = 1'b0;
    end else begin
      chk("req_ready", 256'(req_ready), 256'(!busy));
      chk("start_with_wr", 256'(START & WR), 256'(0));
      if (!WR) chk("din_when_read", 256'(DIN), 256'(0));
      if (!busy) begin
        chk("idle_quiet", 256'({WR, START, rsp_valid}), 256'(0));
      end else begin
        if (WR) begin
          if (wr_seen < w_total)
            chk($sformatf("write%0d", wr_seen), 256'({ADDR, DIN}),
                256'(write_at(m_op, m_nk, m_text, m_key, wr_seen)));
          wr_seen++;
        end
        if (!WR && !START && !rsp_valid && ADDR == 7'h42 && w_total > 0 &&
            wr_seen == w_total && starts == 0)
          n42++;
        if (START) begin
          starts++;
          chk("status_cycles_before_start", 256'(n42), 256'(exp_n42));
          chk("start_cycle", 256'(c), 256'(w_total + exp_n42));
        end
        chk("rsp_valid_timing", 256'(rsp_valid), 256'(c >= exp_lat));
        if (rsp_valid) begin
          chk("rsp_data", 256'(rsp_data), 256'(exp_data));
          chk("rsp_err", 256'(rsp_err), 256'(exp_err));
          if (c == exp_lat) begin
            chk("write_count", 256'(wr_seen), 256'(w_total));
            chk("start_count", 256'(starts), 256'(exp_starts));
          end
          if (rsp_ready) busy = 1'b0;
        end
        c++;
      end
      if (!busy && req_valid && req_ready) begin
        busy = 1'b1;
        m_op = req_op; m_nk = req_nk; m_text = req_text; m_key = req_key;
        c = 0; wr_seen = 0; n42 = 0; starts = 0;
        if (nk_ok(req_nk)) begin
          w_total    = 18 + nb_of(req_nk);
          exp_n42    = 2 * (cfg_full_polls + 1);
          exp_starts = 1;
          if (cfg_ok_delay == 0) begin
            exp_lat  = w_total + exp_n42 + 1 + int'(TO_CYC);
            exp_data = '0;
            exp_err  = 1'b1;
          end else begin
            // OK is seen on the (delay+1)th wait cycle, then 17 read cycles
            exp_lat  = w_total + exp_n42 + 1 + (cfg_ok_delay + 1) + 17;
            exp_data = cfg_result;
            exp_err  = 1'b0;
          end
        end else begin
          w_total = 0; exp_n42 = 0; exp_starts = 0; exp_lat = 0;
          exp_data = '0; exp_err = 1'b1;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_req(input logic op, input logic [2:0] nk,
                          input logic [127:0] text, input logic [255:0] key);
    int guard = 0;
    @(posedge CLK); #1;
    req_valid = 1'b1; req_op = op; req_nk = nk; req_text = text; req_key = key;
    do begin @(negedge CLK); guard++; end while (!req_ready && guard < 200);
    chk("req_accept", 256'(req_ready), 256'(1));
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(input int hold, output logic [127:0] d, output logic e);
    int guard = 0;
    do begin @(negedge CLK); guard++; end while (!rsp_valid && guard < 400);
    chk("rsp_arrives", 256'(rsp_valid), 256'(1));
    d = rsp_data;
    e = rsp_err;
    repeat (hold) @(negedge CLK);
    @(posedge CLK); #1 rsp_ready = 1'b1;
    @(posedge CLK); #1 rsp_ready = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] T0, d;
    logic [255:0] K0, K7;
    logic         e;
    logic [2:0]   bad_nk [5];
    logic [2:0]   nk;
    int           guard;

    T0 = 128'h00112233445566778899aabbccddeeff;
    K0 = {128'h0, 128'h0f0e0d0c0b0a09080706050403020100};
    K7 = {8'ha5, 120'h0, 128'h0f0e0d0c0b0a09080706050403020100};
    bad_nk[0] = 3'd0; bad_nk[1] = 3'd1; bad_nk[2] = 3'd2; bad_nk[3] = 3'd4; bad_nk[4] = 3'd6;

    // Hand-computed pins for the write-order model
    chk("pin_w0",  256'(write_at(1'b1, 3'd3, T0, K0, 0)),  256'({7'h40, 8'h01}));
    chk("pin_w1",  256'(write_at(1'b1, 3'd3, T0, K0, 1)),  256'({7'h41, 8'h03}));
    chk("pin_w2",  256'(write_at(1'b1, 3'd3, T0, K0, 2)),  256'({7'h00, 8'hff}));
    chk("pin_w17", 256'(write_at(1'b1, 3'd3, T0, K0, 17)), 256'({7'h0f, 8'h00}));
    chk("pin_w33", 256'(write_at(1'b1, 3'd3, T0, K0, 33)), 256'({7'h2f, 8'h0f}));
    chk("pin_n7",  256'(18 + nb_of(3'd7)), 256'(50));
    chk("pin_w49", 256'(write_at(1'b0, 3'd7, T0, K7, 49)), 256'({7'h3f, 8'ha5}));

    repeat (3) @(posedge CLK);
    #1 RSTB = 1'b1;

    // AES-128 encrypt, literal result
    cfg_full_polls = 0; cfg_ok_delay = 3; cfg_result = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    send_req(1'b1, 3'd3, T0, K0);
    get_rsp(0, d, e);
    chk("dir_aes128_data", 256'(d), 256'(128'h69c4e0d86a7b0430d8cdb78070b4c55a));
    chk("dir_aes128_err", 256'(e), 256'(0));

    // 256-bit key: 50 writes ending at 0x3F
    cfg_ok_delay = 2; cfg_result = rnd128();
    send_req(1'b0, 3'd7, rnd128(), K7);
    get_rsp(1, d, e);

    // Core full for 3 polls
    cfg_full_polls = 3; cfg_ok_delay = 1; cfg_result = rnd128();
    send_req(1'b1, 3'd5, rnd128(), {rnd128(), rnd128()});
    get_rsp(0, d, e);
    cfg_full_polls = 0;

    // Bad key code
    send_req(1'b1, 3'b100, rnd128(), {rnd128(), rnd128()});
    get_rsp(2, d, e);
    chk("bad_nk_data", 256'(d), 256'(0));
    chk("bad_nk_err", 256'(e), 256'(1));

    // Response held for 5 cycles
    cfg_ok_delay = 4; cfg_result = rnd128();
    send_req(1'b0, 3'd3, rnd128(), {rnd128(), rnd128()});
    get_rsp(5, d, e);

    // Reset during key writes, then a normal request
    send_req(1'b1, 3'd3, rnd128(), {rnd128(), rnd128()});
    guard = 0;
    do begin @(negedge CLK); guard++; end while (!(WR && ADDR >= 7'h20) && guard < 100);
    chk("reached_key_writes", 256'(WR && ADDR >= 7'h20), 256'(1));
    @(posedge CLK); #2 RSTB = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RSTB = 1'b1;
    cfg_ok_delay = 2; cfg_result = rnd128();
    send_req(1'b1, 3'd3, rnd128(), {rnd128(), rnd128()});
    get_rsp(0, d, e);

`ifdef AES_HOST_TIMEOUT_EN
    // OK never rises
    cfg_ok_delay = 0;
    send_req(1'b1, 3'd3, rnd128(), {rnd128(), rnd128()});
    get_rsp(0, d, e);
    chk("timeout_err", 256'(e), 256'(1));
    chk("timeout_data", 256'(d), 256'(0));
    cfg_ok_delay = 2; cfg_result = rnd128();
    send_req(1'b0, 3'd5, rnd128(), {rnd128(), rnd128()});
    get_rsp(0, d, e);
`endif

    // Randomized traffic
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 9) < 8) nk = 3'(2 * $urandom_range(1, 3) + 1);
      else nk = bad_nk[$urandom_range(0, 4)];
      cfg_full_polls = $urandom_range(0, 3);
      cfg_ok_delay   = $urandom_range(1, 6);
      cfg_result     = rnd128();
      send_req(1'($urandom_range(0, 1)), nk, rnd128(), {rnd128(), rnd128()});
      get_rsp($urandom_range(0, 3), d, e);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
    end

    repeat (3) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
